// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to unsigned binary converter: one digit per clock, MSD first,
// acc = acc*10 + digit, with a START/BUSY/DONE handshake and a non-decimal digit flag.
module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   BCD,
  output logic [BIN_W-1:0]      BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t             state_q;
  logic [SR_W-1:0]    sr_q;
  logic [BIN_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_acc_q;
  logic [BIN_W-1:0]   bin_q;
  logic               err_q;
  logic               busy_q;
  logic               done_q;

  logic [3:0]         digit;
  logic [BIN_W-1:0]   acc_d;
  logic               err_d;
  logic               last;
  logic               accept;

  // acc*10 as (acc<<3)+(acc<<1); everything truncates to BIN_W, so wrap is modulo 2^BIN_W.
  always_comb begin
    digit  = sr_q[SR_W-1 -: 4];
    acc_d  = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
    err_d  = err_acc_q | (digit > 4'd9);
    last   = (state_q == CONV) && (cnt_q == CNT_W'(DIGITS - 1));
    // A new request is taken in IDLE or on the final digit edge, giving back-to-back conversions.
    accept = START && ((state_q == IDLE) || last);
  end

  // NOTE: sequential state uses non-blocking assignments only; where two statements below
  // assign the same register on one edge, the later one (the new-request load) wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        CONV: begin
          acc_q     <= acc_d;
          err_acc_q <= err_d;
          sr_q      <= sr_q << 4;
          cnt_q     <= cnt_q + 1'b1;
          if (last) begin
            bin_q   <= acc_d;
            err_q   <= err_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        sr_q      <= BCD;
        acc_q     <= '0;
        cnt_q     <= '0;
        err_acc_q <= 1'b0;
        busy_q    <= 1'b1;
        state_q   <= CONV;
      end
    end
  end

  assign BIN  = bin_q;
  assign ERR  = err_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
